disp_scan_ctrl: RTL and testbench
=================================

// Module: disp_scan_ctrl
// PURPOSE
// Time-multiplexed scanner for the 7-segment display bank; directly upstream of the hex
// segment decoder. Holds one nibble, point and blank flag per digit, scans digits round-robin,
// drives the decoder's D3..D0/point/LE inputs and the active-low anode selects.
// Double-buffered: new display data is applied only at a frame boundary, so no digit tears.
// PARAMETERS
// NDIG      8       number of digits scanned (2..16)
// SCAN_DIV  100000  clk cycles per digit slot (>=2); 1 kHz slot rate at 100 MHz
// GUARD     16      cycles at start of each slot with all anodes off (anti-ghosting), 0<=GUARD<SCAN_DIV
// PORTS
// clk          in   1        system clock
// rst          in   1        synchronous reset, active-high
// hexs         in   4*NDIG   digit nibbles; digit k = hexs[4k+3:4k]
// points       in   NDIG     decimal-point enable per digit, 1 = dp lit
// les          in   NDIG     blank per digit, 1 = digit dark
// update       in   1        1-cycle strobe: capture hexs/points/les into staging
// pending      out  1        staging holds data not yet applied
// frame_done   out  1        1-cycle pulse when digit NDIG-1 slot ends (frame wrap)
// scan_idx     out  clog2(NDIG)  digit currently selected
// digit_hex    out  4        to decoder {D3,D2,D1,D0}
// digit_point  out  1        to decoder point
// digit_le     out  1        to decoder LE (1 = blank)
// an           out  NDIG     anode selects, active-low, one-hot-low or all-ones
// BEHAVIOUR
// - Reset (sync, wins over all): prescaler=0, scan_idx=0, staging/active hex=0, points=0,
//   les=all 1; an=all 1, digit_hex=0, digit_point=0, digit_le=1, pending=0, frame_done=0.
// - Prescaler pre counts 0..SCAN_DIV-1, wraps; width clog2(SCAN_DIV). slot_end = (pre==SCAN_DIV-1).
// - On slot_end: scan_idx <= (scan_idx==NDIG-1) ? 0 : scan_idx+1. wrap = slot_end && idx==NDIG-1.
// - frame_done asserted for exactly the cycle after wrap (registered).
// - update: staging <= {hexs,points,les}; pending <= 1. Any number of updates per frame; last wins.
// - On wrap with pending=1 and no update: active <= staging, pending <= 0.
// - update coincident with wrap: the presented inputs load into both staging and active;
//   pending <= 0. Wrap with pending=0: active unchanged.
// - All outputs registered. digit_hex/point/le = active[scan_idx] fields, valid in the cycle
//   after scan_idx changes (1-cycle latency); they track the new frame's data 1 cycle after wrap.
// - an: all 1 while pre < GUARD of the current slot (as seen 1 cycle earlier, aligned with
//   digit_* latency); otherwise an[scan_idx]=0, rest 1. GUARD=0: no dark gap.
// - A blanked digit (les bit=1) still gets its anode slot; digit_le=1 darkens it in the decoder.
// - Reset mid-frame: staging contents and pending discarded; scan restarts at digit 0 with
//   all digits blank until first update + wrap.
// STRUCTURE
// - disp_pkg: MAX_NDIG=16, ANODE_OFF constant, typedef struct {hex[3:0],point,le} digit_t.
// - Sub-module clk_tick_gen (#(DIV)): prescaler producing 1-cycle tick at count DIV-1;
//   reusable for keypad/scan timing elsewhere. Buffer/scan logic stays in this module.
// TESTING (bench with NDIG=4, SCAN_DIV=4, GUARD=1)
// - Reset: hold rst 3 cycles -> an=4'b1111, digit_le=1, digit_hex=0, pending=0, scan_idx=0.
// - Scan order: after update hexs=16'h4321, les=0 and one wrap -> an low-bit walks 0,1,2,3,0,
//   each slot 4 cycles with first cycle an=1111; digit_hex follows 1,2,3,4.
// - Tear-free: update 16'hABCD mid-frame -> pending=1, display still 1,2,3,4 until frame_done;
//   next frame shows D,C,B,A; pending=0.
// - Coincident: update 16'h00F0 on wrap cycle -> pending stays 0, next frame shows 0,F,0,0.
// - Blank/point: les=4'b0100, points=4'b0001 -> digit 2 digit_le=1 (an still pulses), digit 0 digit_point=1.
// - Reset mid-frame with pending=1 -> pending=0, scan_idx=0, all digits blank after release.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and constants for the 7-segment display scan path.
package disp_pkg;

  localparam int unsigned MAX_NDIG = 16;

  // Anode pattern with every digit switched off (anodes are active-low).
  localparam logic [MAX_NDIG-1:0] ANODE_OFF = '1;

  // One display digit as presented to the hex segment decoder.
  typedef struct packed {
    logic [3:0] hex;
    logic       point;
    logic       le;
  } digit_t;

  // Power-up / reset content: value 0, no point, blanked.
  localparam digit_t DIGIT_BLANK = '{hex: 4'h0, point: 1'b0, le: 1'b1};

endpackage

// File: rtl/clk_tick_gen.sv
// Free-running prescaler: counts 0..DIV-1 and flags the last count.
//   clk, rst : clock, synchronous active-high reset
//   cnt      : current prescaler count (registered)
//   tick_c   : high while cnt == DIV-1 (combinational from the count flop)
module clk_tick_gen #(
  parameter  int unsigned DIV   = 4,
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] cnt,
  output logic             tick_c
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_c = (cnt_q == LAST);
  assign cnt    = cnt_q;

  // Wrap to zero after the last count.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (tick_c) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Double-buffered round-robin scanner for a multiplexed 7-segment bank.
//   hexs/points/les + update : new display content, captured into staging
//   pending                  : staging not yet copied to the active buffer
//   frame_done               : one-cycle pulse after the last digit slot ends
//   scan_idx                 : digit currently being scanned
//   digit_hex/point/le       : fields of the scanned digit, to the segment decoder
//   an                       : active-low anode selects, dark during the guard window
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter  int unsigned NDIG     = 8,
  parameter  int unsigned SCAN_DIV = 100000,
  parameter  int unsigned GUARD    = 16,
  localparam int unsigned IDX_W    = $clog2(NDIG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4*NDIG-1:0] hexs,
  input  logic [NDIG-1:0]   points,
  input  logic [NDIG-1:0]   les,
  input  logic              update,
  output logic              pending,
  output logic              frame_done,
  output logic [IDX_W-1:0]  scan_idx,
  output logic [3:0]        digit_hex,
  output logic              digit_point,
  output logic              digit_le,
  output logic [NDIG-1:0]   an
);

  localparam int unsigned      PRE_W    = $clog2(SCAN_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);
  localparam logic [PRE_W-1:0] GUARD_V  = PRE_W'(GUARD);

  logic [PRE_W-1:0] pre;
  logic             slot_end_c;
  logic             wrap_c;

  digit_t           in_dig_c [NDIG];
  digit_t           stg_q    [NDIG];
  digit_t           stg_d    [NDIG];
  digit_t           act_q    [NDIG];
  digit_t           act_d    [NDIG];
  logic             pending_q,     pending_d;
  logic             frame_done_q,  frame_done_d;
  logic [IDX_W-1:0] scan_idx_q,    scan_idx_d;
  logic [3:0]       digit_hex_q,   digit_hex_d;
  logic             digit_point_q, digit_point_d;
  logic             digit_le_q,    digit_le_d;
  logic [NDIG-1:0]  an_q,          an_d;

  clk_tick_gen #(.DIV(SCAN_DIV)) u_slot_tick (
    .clk    (clk),
    .rst    (rst),
    .cnt    (pre),
    .tick_c (slot_end_c)
  );

  assign wrap_c = slot_end_c && (scan_idx_q == LAST_IDX);

  // Next-state: staging/active buffers, scan index and registered outputs.
  always_comb begin
    stg_d        = stg_q;
    act_d        = act_q;
    pending_d    = pending_q;
    scan_idx_d   = scan_idx_q;
    frame_done_d = wrap_c;

    for (int k = 0; k < NDIG; k++) begin
      in_dig_c[k] = '{hex: hexs[4*k +: 4], point: points[k], le: les[k]};
    end

    if (slot_end_c) begin
      scan_idx_d = (scan_idx_q == LAST_IDX) ? '0 : scan_idx_q + IDX_W'(1);
    end

    if (update) begin
      stg_d     = in_dig_c;
      pending_d = 1'b1;
    end

    // Frame boundary: an update arriving on this very cycle bypasses staging.
    if (wrap_c) begin
      if (update) begin
        act_d     = in_dig_c;
        pending_d = 1'b0;
      end else if (pending_q) begin
        act_d     = stg_q;
        pending_d = 1'b0;
      end
    end

    digit_hex_d   = act_q[scan_idx_q].hex;
    digit_point_d = act_q[scan_idx_q].point;
    digit_le_d    = act_q[scan_idx_q].le;

    // Anodes use the same pre-edge index/count as digit_*, keeping them aligned.
    an_d = ANODE_OFF[NDIG-1:0];
    if (!(pre < GUARD_V)) an_d[scan_idx_q] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NDIG; k++) begin
        stg_q[k] <= DIGIT_BLANK;
        act_q[k] <= DIGIT_BLANK;
      end
      pending_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      scan_idx_q    <= '0;
      digit_hex_q   <= 4'h0;
      digit_point_q <= 1'b0;
      digit_le_q    <= 1'b1;
      an_q          <= ANODE_OFF[NDIG-1:0];
    end else begin
      stg_q         <= stg_d;
      act_q         <= act_d;
      pending_q     <= pending_d;
      frame_done_q  <= frame_done_d;
      scan_idx_q    <= scan_idx_d;
      digit_hex_q   <= digit_hex_d;
      digit_point_q <= digit_point_d;
      digit_le_q    <= digit_le_d;
      an_q          <= an_d;
    end
  end

  assign pending     = pending_q;
  assign frame_done  = frame_done_q;
  assign scan_idx    = scan_idx_q;
  assign digit_hex   = digit_hex_q;
  assign digit_point = digit_point_q;
  assign digit_le    = digit_le_q;
  assign an          = an_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with NDIG=4, SCAN_DIV=4, GUARD=1.
module tb_disp_scan_ctrl;

  localparam int unsigned NDIG     = 4;
  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned GUARD    = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] hexs;
  logic [3:0]  points;
  logic [3:0]  les;
  logic        update;
  logic        pending;
  logic        frame_done;
  logic [1:0]  scan_idx;
  logic [3:0]  digit_hex;
  logic        digit_point;
  logic        digit_le;
  logic [3:0]  an;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  disp_scan_ctrl #(.NDIG(NDIG), .SCAN_DIV(SCAN_DIV), .GUARD(GUARD)) dut (
    .clk         (clk),
    .rst         (rst),
    .hexs        (hexs),
    .points      (points),
    .les         (les),
    .update      (update),
    .pending     (pending),
    .frame_done  (frame_done),
    .scan_idx    (scan_idx),
    .digit_hex   (digit_hex),
    .digit_point (digit_point),
    .digit_le    (digit_le),
    .an          (an)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until the frame_done pulse is visible, bounded by a cycle budget.
  task automatic wait_frame_done(input int budget);
    int n = 0;
    while (frame_done !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk("frame_done_wait", 16'(frame_done), 16'(1'b1));
  endtask

  // Entered right after frame_done is seen; checks the 16 cycles of the next frame.
  // Optionally pulses update at cycle upd_at (15 = coincident with the wrap).
  task automatic check_frame(input logic [15:0] exp_hex, input logic [3:0] exp_le,
                             input logic [3:0] exp_pt, input int upd_at,
                             input logic [15:0] u_hex, input logic [3:0] u_le,
                             input logic [3:0] u_pt);
    logic [3:0] one;
    logic [3:0] exp_an;
    int         slot;
    one = 4'b0001;
    for (int c = 0; c < 16; c++) begin
      if (c == upd_at) begin
        update = 1'b1;
        hexs   = u_hex;
        les    = u_le;
        points = u_pt;
      end
      step();
      update = 1'b0;
      slot   = c / 4;
      exp_an = (c % 4 == 0) ? 4'hF : ~(one << slot);
      chk("an",          16'(an),          16'(exp_an));
      chk("digit_hex",   16'(digit_hex),   16'(exp_hex[4*slot +: 4]));
      chk("digit_le",    16'(digit_le),    16'(exp_le[slot]));
      chk("digit_point", 16'(digit_point), 16'(exp_pt[slot]));
      chk("scan_idx",    16'(scan_idx),    16'(((c + 1) / 4) % 4));
      chk("frame_done",  16'(frame_done),  16'(c == 15));
      if (c == upd_at) chk("pending_after_update", 16'(pending), 16'(c != 15));
    end
    chk("pending_end", 16'(pending), 16'(1'b0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    update = 1'b0;
    hexs   = 16'h0;
    points = 4'h0;
    les    = 4'h0;

    // Reset held three cycles.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_an",         16'(an),         16'hF);
      chk("rst_digit_le",   16'(digit_le),   16'(1'b1));
      chk("rst_digit_hex",  16'(digit_hex),  16'h0);
      chk("rst_pending",    16'(pending),    16'(1'b0));
      chk("rst_scan_idx",   16'(scan_idx),   16'h0);
      chk("rst_frame_done", 16'(frame_done), 16'(1'b0));
    end

    // First content: 4321, nothing blank.
    rst    = 1'b0;
    update = 1'b1;
    hexs   = 16'h4321;
    les    = 4'h0;
    points = 4'h0;
    step();
    update = 1'b0;
    chk("pending_first", 16'(pending), 16'(1'b1));
    wait_frame_done(40);

    // Scan order 1,2,3,4; ABCD arrives mid-frame and must not tear it.
    check_frame(16'h4321, 4'h0, 4'h0, 5, 16'hABCD, 4'h0, 4'h0);
    // ABCD frame; 00F0 arrives on the wrap cycle itself.
    check_frame(16'hABCD, 4'h0, 4'h0, 15, 16'h00F0, 4'h0, 4'h0);
    // Coincident data shows immediately; queue a blank/point pattern.
    check_frame(16'h00F0, 4'h0, 4'h0, 3, 16'h5678, 4'b0100, 4'b0001);
    // Digit 2 blanked but still scanned, digit 0 has its point.
    check_frame(16'h5678, 4'b0100, 4'b0001, 7, 16'h9999, 4'h0, 4'h0);
    check_frame(16'h9999, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0);

    // Reset in the middle of a frame with data pending.
    update = 1'b1;
    hexs   = 16'h1111;
    step();
    update = 1'b0;
    chk("pending_before_rst", 16'(pending), 16'(1'b1));
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_pending",  16'(pending),  16'(1'b0));
    chk("midrst_scan_idx", 16'(scan_idx), 16'h0);
    chk("midrst_an",       16'(an),       16'hF);
    chk("midrst_le",       16'(digit_le), 16'(1'b1));
    wait_frame_done(40);
    // Pending data was discarded: every digit stays blank.
    check_frame(16'h0000, 4'hF, 4'h0, -1, 16'h0, 4'h0, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
